noise_arbiter: RTL and testbench

NOISE_ARBITER -- requirements
Module: noise_arbiter

---
 rtl/noise_arbiter_pkg.sv | 16 +
 rtl/noise_arbiter_lfsr.sv | 33 +++
 rtl/noise_arbiter.sv | 158 +++++++++++++++
 tb/tb_noise_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_arbiter_pkg.sv
// Shared constants for the noise arbiter: FSM state encodings, LFSR tap masks
// and the all-ones reset seed.
package noise_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEED  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  // Feedback taps: bits whose XOR becomes the new MSB after a right shift.
  localparam logic [7:0] TAP_MASK8 = 8'h1D;  // bits 0,2,3,4
  localparam logic [3:0] TAP_MASK4 = 4'h3;   // bits 0,1

  localparam logic [7:0] RESET_SEED8 = 8'hFF;
  localparam logic [3:0] RESET_SEED4 = 4'hF;

endpackage

// File: rtl/noise_arbiter_lfsr.sv
// Right-shifting Fibonacci LFSR; load wins over step, otherwise the word holds.
module noise_lfsr_core
  import noise_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] word
);

  localparam logic [N-1:0] TAP  = (N == 8) ? N'(TAP_MASK8)   : N'(TAP_MASK4);
  localparam logic [N-1:0] ONES = (N == 8) ? N'(RESET_SEED8) : N'(RESET_SEED4);

  logic [N-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (load)      word_d = load_value;
    else if (step) word_d = {^(word_q & TAP), word_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) word_q <= ONES;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/noise_arbiter.sv
// Round-robin arbiter granting bursts of LFSR noise words to one requester at
// a time, with deferred reseeding between bursts.
module noise_arbiter
  import noise_arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [N-1:0]    noise_data,
  output logic            noise_valid,
  input  logic            noise_ready,
  input  logic            seed_load,
  input  logic [N-1:0]    seed_value,
  output logic            busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [N-1:0] ONES = (N == 8) ? N'(RESET_SEED8) : N'(RESET_SEED4);

  if (N != 4 && N != 8) begin : g_bad_n
    $error("noise_arbiter: N must be 4 or 8");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("noise_arbiter: NREQ must be in 2..8");
  end
  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("noise_arbiter: BURST must be in 1..15");
  end

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            pend_q, pend_d;
  logic [N-1:0]    seed_q, seed_d;

  logic            xfer, owner_req, burst_done;
  logic [3:0]      cnt_inc;
  logic [PW-1:0]   ptr_next;
  logic            lfsr_load;
  logic [N-1:0]    lfsr_seed;

  // Round-robin search: rotate req so bit 0 is the pointer position.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              win_found;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win_idx;

  always_comb begin
    req_dbl   = {req, req};
    req_rot   = NREQ'(req_dbl >> ptr_q);
    win_found = 1'b0;
    win_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_sum   = (PW+1)'(ptr_q) + (PW+1)'(i);
      end
    end
    win_idx = (win_sum >= (PW+1)'(NREQ)) ? PW'(win_sum - (PW+1)'(NREQ)) : PW'(win_sum);
  end

  assign xfer       = (state_q == ST_BURST) && noise_ready;
  assign owner_req  = |(req & grant_q);
  assign cnt_inc    = cnt_q + 4'd1;
  assign burst_done = xfer && (cnt_inc == 4'(BURST));
  assign ptr_next   = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    pend_d  = pend_q;
    seed_d  = seed_q;

    // A pulse landing on the SEED cycle re-arms the flag for the next IDLE.
    if (state_q == ST_SEED) pend_d = 1'b0;
    if (seed_load) begin
      pend_d = 1'b1;
      seed_d = seed_value;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_SEED;
        end else if (win_found) begin
          state_d = ST_BURST;
          owner_d = win_idx;
          grant_d = NREQ'(1) << win_idx;
          cnt_d   = '0;
        end
      end
      ST_SEED: state_d = ST_IDLE;
      ST_BURST: begin
        if (xfer) cnt_d = cnt_inc;
        if (burst_done || !owner_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = ptr_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      pend_q  <= 1'b0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      seed_q  <= seed_d;
    end
  end

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  assign lfsr_load = (state_q == ST_SEED);
  assign lfsr_seed = (seed_q == '0) ? ONES : seed_q;

  noise_lfsr_core #(.N(N)) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .step       (xfer),
    .load       (lfsr_load),
    .load_value (lfsr_seed),
    .word       (noise_data)
  );

  assign grant       = grant_q;
  assign noise_valid = (state_q == ST_BURST);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noise_arbiter.sv
// Directed bench for noise_arbiter (N=8, NREQ=4, BURST=4); observes
// {grant, noise_valid, busy, noise_data} one time unit after each rising edge.
module tb_noise_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] noise_data;
  logic       noise_valid;
  logic       noise_ready;
  logic       seed_load;
  logic [7:0] seed_value;
  logic       busy;

  int vecs    = 0;
  int miscmp  = 0;
  logic [13:0] obs, exp;
  logic [7:0]  lf;

  assign obs = {grant, noise_valid, busy, noise_data};

  noise_arbiter #(.N(8), .NREQ(4), .BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .noise_data  (noise_data),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(logic [3:0] g, logic v, logic b, logic [7:0] d);
    return {g, v, b, d};
  endfunction

  // x^8+x^6+x^5+x^4+1, right shift, new MSB = b0^b2^b3^b4
  function automatic logic [7:0] nx8(logic [7:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[4], x[7:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; noise_ready = 1'b0; seed_load = 1'b0; seed_value = '0;
    tick(); tick();
    reset = 1'b1;
    lf = 8'hFF;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; noise_ready = 1'b1; seed_load = 1'b1; seed_value = 8'h3C;
    tick(); tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    do_reset();
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL reset_idle_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_single();
    logic [7:0] words [4] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F};
    do_reset();
    noise_ready = 1'b1; req = 4'b0001;
    for (int w = 0; w < 4; w++) begin
      tick();
      if (w == 3) req = 4'b0000;
      exp = mk(4'b0001, 1'b1, 1'b1, words[w]); vecs++;
      if (obs !== exp) begin miscmp++; $display("FAIL single_w%0d: got %h want %h", w, obs, exp); end
    end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL single_done: got %h want %h", obs, exp); end
    // ptr should now be 1, so requester 1 beats requester 0
    req = 4'b0011;
    tick();
    exp = mk(4'b0010, 1'b1, 1'b1, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL single_ptr: got %h want %h", obs, exp); end
    req = 4'b0000;
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h87); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_with_xfer: got %h want %h", obs, exp); end
  endtask

  task automatic test_round_robin();
    logic [3:0] gexp;
    do_reset();
    noise_ready = 1'b1; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gexp = 4'b0001 << (g % 4);
      for (int w = 0; w < 4; w++) begin
        tick();
        exp = mk(gexp, 1'b1, 1'b1, lf); vecs++;
        if (obs !== exp) begin miscmp++; $display("FAIL rr_g%0d_w%0d: got %h want %h", g, w, obs, exp); end
        lf = nx8(lf);
      end
      if (g == 4) req = 4'b0000;
      tick();
      exp = mk(4'b0000, 1'b0, 1'b0, lf); vecs++;
      if (obs !== exp) begin miscmp++; $display("FAIL rr_idle_g%0d: got %h want %h", g, obs, exp); end
    end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, lf); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL rr_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_seed();
    do_reset();
    seed_load = 1'b1; seed_value = 8'hA5;
    tick();
    seed_load = 1'b0; seed_value = 8'h00;
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_pending: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b1, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_state: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hA5); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_loaded: got %h want %h", obs, exp); end
    // zero seed, with a request already waiting: SEED must win
    seed_load = 1'b1; seed_value = 8'h00;
    tick();
    seed_load = 1'b0; req = 4'b0001; noise_ready = 1'b1;
    tick();
    exp = mk(4'b0000, 1'b0, 1'b1, 8'hA5); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_priority: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_zero: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL seed_first_word: got %h want %h", obs, exp); end
    req = 4'b0000; noise_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    noise_ready = 1'b1; req = 4'b0001;
    tick(); tick(); tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h3F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_pre: got %h want %h", obs, exp); end
    req = 4'b0000;
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h1F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_clear: got %h want %h", obs, exp); end
    req = 4'b0001;
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h1F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_resume: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_next: got %h want %h", obs, exp); end
    req = 4'b0000; noise_ready = 1'b0;
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL abort_noxfer: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall();
    do_reset();
    noise_ready = 1'b1; req = 4'b0001;
    tick(); tick();
    noise_ready = 1'b0; seed_load = 1'b1; seed_value = 8'h11;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (s == 0) seed_value = 8'h5A;
      if (s == 1) seed_load = 1'b0;
      exp = mk(4'b0001, 1'b1, 1'b1, 8'h7F); vecs++;
      if (obs !== exp) begin miscmp++; $display("FAIL stall_%0d: got %h want %h", s, obs, exp); end
    end
    noise_ready = 1'b1;
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h3F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_resume: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h1F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_last: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_end: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b1, 8'h0F); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_seed_state: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'h5A); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_reseed: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'h5A); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL stall_regrant: got %h want %h", obs, exp); end
    req = 4'b0000; noise_ready = 1'b0;
    tick();
  endtask

  task automatic test_nonowner();
    do_reset();
    noise_ready = 1'b1; req = 4'b0010;
    tick();
    req = 4'b0011;
    for (int w = 0; w < 4; w++) begin
      exp = mk(4'b0010, 1'b1, 1'b1, lf); vecs++;
      if (obs !== exp) begin miscmp++; $display("FAIL nonowner_w%0d: got %h want %h", w, obs, exp); end
      lf = nx8(lf);
      tick();
    end
    exp = mk(4'b0000, 1'b0, 1'b0, lf); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL nonowner_idle: got %h want %h", obs, exp); end
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, lf); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL rr_wrap: got %h want %h", obs, exp); end
    req = 4'b0000; noise_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    noise_ready = 1'b1; req = 4'b0001;
    tick(); tick();
    reset = 1'b0;
    tick();
    exp = mk(4'b0000, 1'b0, 1'b0, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL reset_mid: got %h want %h", obs, exp); end
    reset = 1'b1;
    tick();
    exp = mk(4'b0001, 1'b1, 1'b1, 8'hFF); vecs++;
    if (obs !== exp) begin miscmp++; $display("FAIL reset_regrant: got %h want %h", obs, exp); end
    req = 4'b0000; noise_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_seed();
    test_abort();
    test_stall();
    test_nonowner();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
